// File: rtl/lif_neuron_array.sv
// Time-multiplexed leaky integrate-and-fire neuron array sharing one 2-stage MAC datapath.
// Define LIF_SPIKE_COUNT_EN to add per-neuron saturating spike counters and the o_cnt port.
module lif_neuron_array #(
  parameter int unsigned N_NEURONS = 4,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned FRAC_W    = 9,
  parameter int unsigned I_W       = 8,
  parameter int unsigned I_SHIFT   = 6,
  parameter int unsigned REF_W     = 4,
  localparam int unsigned NID_W    = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [2:0]        cfg_sel,
  input  logic [NID_W-1:0]  cfg_nid,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              start,
  input  logic              stop,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [I_W-1:0]    i_data,
  output logic              o_valid,
  output logic [NID_W-1:0]  o_nid,
  output logic [DATA_W-1:0] o_v,
  output logic              o_spike,
`ifdef LIF_SPIKE_COUNT_EN
  output logic [7:0]        o_cnt,
`endif
  output logic              busy
);

  localparam int unsigned D1_W = DATA_W + 1;
  localparam int unsigned P_W  = D1_W + DATA_W;
  localparam int unsigned S_W  = P_W + 1;
  localparam int unsigned IS_W = I_W + I_SHIFT;
  localparam logic signed [S_W-1:0] SAT_MAX = {{(S_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [S_W-1:0] SAT_MIN = {{(S_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state, state_d;
  logic   cfg_ready_d, i_ready_d, busy_d;

  logic signed [DATA_W-1:0] e_rest [N_NEURONS];
  logic signed [DATA_W-1:0] e_tau  [N_NEURONS];
  logic signed [DATA_W-1:0] v_th   [N_NEURONS];
  logic signed [DATA_W-1:0] v_init [N_NEURONS];
  logic signed [DATA_W-1:0] v      [N_NEURONS];
  logic signed [DATA_W-1:0] v_init_nx_c [N_NEURONS];
  logic [REF_W-1:0]         t_ref   [N_NEURONS];
  logic [REF_W-1:0]         ref_cnt [N_NEURONS];
  logic [NID_W-1:0]         ptr;

  logic cfg_fire_c, start_fire_c, accept_c;

  logic signed [D1_W-1:0] d_c;
  logic signed [P_W-1:0]  d_ext_c, tau_ext_c, p_c, p_sh_c;

  logic                     s1_valid;
  logic signed [P_W-1:0]    s1_p;
  logic signed [DATA_W-1:0] s1_e_rest;
  logic [IS_W-1:0]          s1_i;
  logic [NID_W-1:0]         s1_nid;

  logic signed [S_W-1:0]    s_c;
  logic signed [DATA_W-1:0] s_sat_c, v_new_c;
  logic [REF_W-1:0]         ref_rd_c, ref_new_c;
  logic                     spike_c;

  assign cfg_fire_c   = cfg_valid && cfg_ready;
  assign start_fire_c = start && (state == IDLE);
  assign accept_c     = i_valid && i_ready;

  // State register with registered handshake/status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cfg_ready <= 1'b1;
      i_ready   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      cfg_ready <= cfg_ready_d;
      i_ready   <= i_ready_d;
      busy      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state;
    cfg_ready_d = 1'b0;
    i_ready_d   = 1'b0;
    busy_d      = 1'b0;
    case (state)
      IDLE:    if (start)     state_d = RUN;
      RUN:     if (stop)      state_d = DRAIN;
      DRAIN:   if (!s1_valid) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
    cfg_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    // Single neuron: skip a cycle after each accept so S1 sees the written-back V
    i_ready_d   = (state_d == RUN) && !((N_NEURONS == 1) && accept_c);
  end

  // V_INIT as seen by a start that coincides with a config write
  always_comb begin
    for (int n = 0; n < N_NEURONS; n++) begin
      v_init_nx_c[n] = v_init[n];
      if (cfg_fire_c && (cfg_sel == 3'd3) && (32'(cfg_nid) == n))
        v_init_nx_c[n] = cfg_data;
    end
  end

  // S1: leak product (V - E_REST) * E_TAU
  assign d_c       = {v[ptr][DATA_W-1], v[ptr]} - {e_rest[ptr][DATA_W-1], e_rest[ptr]};
  assign d_ext_c   = {{(P_W-D1_W){d_c[D1_W-1]}}, d_c};
  assign tau_ext_c = {{(P_W-DATA_W){e_tau[ptr][DATA_W-1]}}, e_tau[ptr]};
  assign p_c       = d_ext_c * tau_ext_c;
  assign p_sh_c    = p_c >>> FRAC_W;

  // S2: full-width sum, saturate, threshold and refractory update
  assign s_c = {{(S_W-P_W){s1_p[P_W-1]}}, s1_p}
             + {{(S_W-DATA_W){s1_e_rest[DATA_W-1]}}, s1_e_rest}
             + {{(S_W-IS_W){1'b0}}, s1_i};

  always_comb begin
    s_sat_c   = s_c[DATA_W-1:0];
    if (s_c > SAT_MAX) s_sat_c = {1'b0, {(DATA_W-1){1'b1}}};
    if (s_c < SAT_MIN) s_sat_c = {1'b1, {(DATA_W-1){1'b0}}};
    ref_rd_c  = ref_cnt[s1_nid];
    v_new_c   = s_sat_c;
    ref_new_c = '0;
    spike_c   = 1'b0;
    if (ref_rd_c != '0) begin
      v_new_c   = s1_e_rest;
      ref_new_c = ref_rd_c - 1'b1;
    end else if (s_sat_c >= v_th[s1_nid]) begin
      v_new_c   = s1_e_rest;
      ref_new_c = t_ref[s1_nid];
      spike_c   = 1'b1;
    end
  end

`ifdef LIF_SPIKE_COUNT_EN
  logic [7:0] cnt [N_NEURONS];
  logic [7:0] cnt_new_c;
  assign cnt_new_c = (spike_c && (cnt[s1_nid] != 8'hFF)) ? cnt[s1_nid] + 8'd1 : cnt[s1_nid];
`endif

  // Register files, round-robin pointer and pipeline registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int n = 0; n < N_NEURONS; n++) begin
        e_rest[n]  <= '0;
        e_tau[n]   <= '0;
        v_th[n]    <= '0;
        v_init[n]  <= '0;
        v[n]       <= '0;
        t_ref[n]   <= '0;
        ref_cnt[n] <= '0;
`ifdef LIF_SPIKE_COUNT_EN
        cnt[n]     <= '0;
`endif
      end
      ptr       <= '0;
      s1_valid  <= 1'b0;
      s1_p      <= '0;
      s1_e_rest <= '0;
      s1_i      <= '0;
      s1_nid    <= '0;
      o_valid   <= 1'b0;
      o_nid     <= '0;
      o_v       <= '0;
      o_spike   <= 1'b0;
`ifdef LIF_SPIKE_COUNT_EN
      o_cnt     <= '0;
`endif
    end else begin
      if (cfg_fire_c && (32'(cfg_nid) < N_NEURONS)) begin
        case (cfg_sel)
          3'd0:    e_rest[cfg_nid] <= cfg_data;
          3'd1:    e_tau[cfg_nid]  <= cfg_data;
          3'd2:    v_th[cfg_nid]   <= cfg_data;
          3'd3:    v_init[cfg_nid] <= cfg_data;
          3'd4:    t_ref[cfg_nid]  <= cfg_data[REF_W-1:0];
          default: ;
        endcase
      end
      if (start_fire_c) begin
        for (int n = 0; n < N_NEURONS; n++) begin
          v[n]       <= v_init_nx_c[n];
          ref_cnt[n] <= '0;
`ifdef LIF_SPIKE_COUNT_EN
          cnt[n]     <= '0;
`endif
        end
        ptr <= '0;
      end
      s1_valid <= accept_c;
      if (accept_c) begin
        s1_p      <= p_sh_c;
        s1_e_rest <= e_rest[ptr];
        s1_i      <= IS_W'(i_data) << I_SHIFT;
        s1_nid    <= ptr;
        ptr       <= (32'(ptr) == N_NEURONS - 1) ? '0 : ptr + 1'b1;
      end
      o_valid <= s1_valid;
      if (s1_valid) begin
        v[s1_nid]       <= v_new_c;
        ref_cnt[s1_nid] <= ref_new_c;
        o_nid           <= s1_nid;
        o_v             <= v_new_c;
        o_spike         <= spike_c;
`ifdef LIF_SPIKE_COUNT_EN
        cnt[s1_nid]     <= cnt_new_c;
        o_cnt           <= cnt_new_c;
`endif
      end
    end
  end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed bench for lif_neuron_array: vector tables for neuron dynamics plus
// hand sequences for config lockout, drain, mid-run reset and (LIF_SPIKE_COUNT_EN) counters.
module tb_lif_neuron_array;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [2:0]  cfg_sel;
  logic [1:0]  cfg_nid;
  logic [15:0] cfg_data;
  logic        start, stop;
  logic        i_valid, i_ready;
  logic [7:0]  i_data;
  logic        o_valid;
  logic [1:0]  o_nid;
  logic [15:0] o_v;
  logic        o_spike;
  logic        busy;
`ifdef LIF_SPIKE_COUNT_EN
  logic [7:0]  o_cnt;
`endif

  lif_neuron_array dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sel(cfg_sel),
    .cfg_nid(cfg_nid), .cfg_data(cfg_data),
    .start(start), .stop(stop),
    .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
    .o_valid(o_valid), .o_nid(o_nid), .o_v(o_v), .o_spike(o_spike),
`ifdef LIF_SPIKE_COUNT_EN
    .o_cnt(o_cnt),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int i;
    int nid;
    int v;
    int spike;
  } vec_t;

  vec_t tv [0:31];
  int   ntv;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input int i, input int nid, input int v, input int spike);
    tv[ntv] = '{i, nid, v, spike};
    ntv++;
  endtask

  task automatic cfg_write(input int sel, input int nid, input int data);
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_sel = 3'(sel); cfg_nid = 2'(nid); cfg_data = 16'(data);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic cfg_all(input int sel, input int data);
    for (int n = 0; n < 4; n++) cfg_write(sel, n, data);
  endtask

  task automatic do_start();
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic stop_drain(input string name);
    @(posedge clk); #1; stop = 1'b1;
    @(posedge clk); #1; stop = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk({name, "_drain_busy"}, busy, 0);
  endtask

  // Stream the table one sample per cycle; result k must appear 2 cycles after its accept
  task automatic run_vecs(input string name);
    for (int j = 0; j < ntv + 2; j++) begin
      @(posedge clk); #1;
      if (j < ntv) begin i_valid = 1'b1; i_data = 8'(tv[j].i); end
      else i_valid = 1'b0;
      @(negedge clk);
      if (j < ntv) chk($sformatf("%s_iready[%0d]", name, j), i_ready, 1);
      if (j >= 2) begin
        chk($sformatf("%s_ovalid[%0d]", name, j-2), o_valid, 1);
        chk($sformatf("%s_nid[%0d]", name, j-2), o_nid, tv[j-2].nid);
        chk($sformatf("%s_v[%0d]", name, j-2), $signed(o_v), tv[j-2].v);
        chk($sformatf("%s_spike[%0d]", name, j-2), o_spike, tv[j-2].spike);
      end else begin
        chk($sformatf("%s_early_ovalid[%0d]", name, j), o_valid, 0);
      end
    end
    ntv = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, outs, last_nid, seen;
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_sel = '0; cfg_nid = '0; cfg_data = '0;
    start = 1'b0; stop = 1'b0; i_valid = 1'b0; i_data = '0; ntv = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_i_ready", i_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_v", o_v, 0);
    chk("rst_o_nid", o_nid, 0);
    chk("rst_o_spike", o_spike, 0);

    // Pure leak at 0.5 per visit from V_INIT=1024
    cfg_all(1, 256); cfg_all(2, 15360); cfg_all(3, 1024);
    do_start();
    @(negedge clk);
    chk("run_busy", busy, 1);
    chk("run_cfg_ready", cfg_ready, 0);
    for (int k = 0; k < 12; k++) add(0, k % 4, 512 >> (k / 4), 0);
    run_vecs("leak");
    stop_drain("leak");

    // Strong input on neuron 2 only crosses threshold
    do_start();
    add(0, 0, 512, 0); add(0, 1, 512, 0); add(255, 2, 0, 1); add(0, 3, 512, 0);
    add(0, 0, 256, 0); add(0, 1, 256, 0); add(0, 2, 0, 0);   add(0, 3, 256, 0);
    run_vecs("spike");
    stop_drain("spike");

    // Refractory period of 3 visits on neuron 0
    cfg_write(4, 0, 3);
    do_start();
    add(255, 0, 0, 1); add(0, 1, 512, 0); add(0, 2, 512, 0); add(0, 3, 512, 0);
    for (int r = 0; r < 3; r++) begin
      add(255, 0, 0, 0);
      for (int n = 1; n < 4; n++) add(0, n, 256 >> r, 0);
    end
    add(255, 0, 0, 1); add(0, 1, 32, 0); add(0, 2, 32, 0); add(0, 3, 32, 0);
    run_vecs("refr");
    stop_drain("refr");

    // Threshold equality, positive/negative saturation
    cfg_write(2, 1, 512);
    cfg_write(0, 2, -32768); cfg_write(3, 2, 32767); cfg_write(1, 2, -512); cfg_write(2, 2, 0);
    cfg_write(0, 3, -32768); cfg_write(3, 3, 32767); cfg_write(1, 3, 511); cfg_write(2, 3, 32767);
    do_start();
    add(0, 0, 512, 0); add(0, 1, 0, 1);   add(0, 2, -32768, 0); add(255, 3, -32768, 1);
    add(0, 0, 256, 0); add(255, 1, 0, 1); add(0, 2, -32768, 0); add(0, 3, -32768, 0);
    run_vecs("sat");
    stop_drain("sat");

    // Config write while running is refused
    do_start();
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_sel = 3'd3; cfg_nid = 2'd0; cfg_data = 16'd100;
    @(negedge clk);
    chk("run_cfg_refused_ready", cfg_ready, 0);
    @(posedge clk); #1 cfg_valid = 1'b0;
    stop_drain("cfgrun");
    do_start();
    add(0, 0, 512, 0);
    run_vecs("cfgrun");
    stop_drain("cfgrun2");

    // Config write coinciding with start feeds the V load
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_sel = 3'd3; cfg_nid = 2'd0; cfg_data = 16'd2048; start = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0; start = 1'b0;
    add(0, 0, 1024, 0);
    run_vecs("cfgstart");
    stop_drain("cfgstart");

    // Stop under continuous input: the stop-cycle sample still completes
    do_start();
    acc = 0; outs = 0; last_nid = -1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      i_valid = 1'b1; i_data = 8'd0; stop = (c == 3);
      @(negedge clk);
      if (i_valid && i_ready) acc++;
      if (o_valid) begin outs++; last_nid = int'(o_nid); end
      if (c > 3 && !busy) break;
    end
    #1 i_valid = 1'b0; stop = 1'b0;
    chk("stop_accepts", acc, 4);
    chk("stop_outputs", outs, 4);
    chk("stop_last_nid", last_nid, 3);
    chk("stop_busy", busy, 0);
    chk("stop_i_ready", i_ready, 0);
    chk("stop_cfg_ready", cfg_ready, 1);
    chk("stop_no_extra_ovalid", o_valid, 0);

    // Reset while a sample is in flight
    do_start();
    @(posedge clk); #1; i_valid = 1'b1; i_data = 8'd0;
    @(posedge clk); #1; rst_n = 1'b0; i_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rstrun_ovalid[%0d]", k), o_valid, 0);
      if (k == 0) begin @(posedge clk); #1 rst_n = 1'b1; end
    end
    chk("rstrun_o_v", o_v, 0);
    chk("rstrun_o_nid", o_nid, 0);
    chk("rstrun_o_spike", o_spike, 0);
    chk("rstrun_busy", busy, 0);
    chk("rstrun_i_ready", i_ready, 0);
    chk("rstrun_cfg_ready", cfg_ready, 1);

`ifdef LIF_SPIKE_COUNT_EN
    // All-zero config: every visit spikes; neuron 1 gets 300 spikes
    do_start();
    seen = 0;
    for (int c = 0; c < 1200; c++) begin
      @(posedge clk); #1; i_valid = 1'b1; i_data = 8'd0;
      @(negedge clk);
      if (o_valid && o_nid == 2'd1) begin
        seen++;
        chk($sformatf("cnt[%0d]", seen), o_cnt, (seen > 255) ? 255 : seen);
      end
    end
    #1 i_valid = 1'b0;
    chk("cnt_visits", seen, 300);
    stop_drain("cnt");
    do_start();
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1; i_valid = (c < 2);
      @(negedge clk);
      if (o_valid && o_nid == 2'd1) begin
        seen++;
        chk("cnt_restart", o_cnt, 1);
      end
    end
    chk("cnt_restart_seen", seen, 1);
    stop_drain("cnt2");
`else
    acc = 0; outs = 0; last_nid = 0; seen = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
